// File: rtl/input_port_ctrl_pkg.sv
// Shared constants for the memory-mapped input-port peripheral:
// register offsets within the 8-word window and CTRL field positions.
package input_port_pkg;

    localparam logic [2:0] OFF_LEVEL = 3'd0;
    localparam logic [2:0] OFF_RISE  = 3'd1;
    localparam logic [2:0] OFF_FALL  = 3'd2;
    localparam logic [2:0] OFF_CTRL  = 3'd3;
    localparam logic [2:0] OFF_CNT0  = 3'd4;
    localparam logic [2:0] OFF_CNT1  = 3'd5;

    localparam int BYPASS_LSB  = 0;
    localparam int IRQMASK_LSB = 8;
    localparam int IRQMASK_W   = 8;

endpackage

// File: rtl/input_port_ctrl_if.sv
// Load/store bus between the core's address decoder and the input-port block.
interface input_port_ctrl_if #(
    parameter int BUS_SIZE = 32
);
    logic [7:0]          dirSelect;
    logic                wrEn;
    logic [BUS_SIZE-1:0] writeData;
    logic                hit;
    logic [BUS_SIZE-1:0] readData;

    modport master (output dirSelect, wrEn, writeData, input hit, readData);
    modport slave  (input dirSelect, wrEn, writeData, output hit, readData);
endinterface

// File: rtl/input_port_ctrl_debouncer.sv
// One input pin: 2-FF synchroniser, stability counter and accepted level.
// Edge pulses are taken from the level about to be loaded, so flags set on the same edge.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic bypass,
    output logic level,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DBW-1:0] DB_ONE  = DBW'(1);
    localparam logic [DBW-1:0] DB_ZERO = DBW'(0);

    logic           sync1_q, sync1_d;
    logic           sync2_q, sync2_d;
    logic           level_q, level_d;
    logic [DBW-1:0] db_cnt_q, db_cnt_d;

    // Next-state: accept a new level once it has been stable long enough
    always_comb begin
        sync1_d  = pin;
        sync2_d  = sync1_q;
        level_d  = level_q;
        db_cnt_d = DB_ZERO;
        if (sync2_q == level_q) begin
            db_cnt_d = DB_ZERO;
        end else if ((db_cnt_q == DB_LAST) || bypass) begin
            level_d  = sync2_q;
            db_cnt_d = DB_ZERO;
        end else begin
            db_cnt_d = db_cnt_q + DB_ONE;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            level_q  <= 1'b0;
            db_cnt_q <= DB_ZERO;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            level_q  <= level_d;
            db_cnt_q <= db_cnt_d;
        end
    end

    assign level      = level_q;
    assign rise_pulse = level_d & ~level_q;
    assign fall_pulse = ~level_d & level_q;

endmodule

// File: rtl/input_port_ctrl.sv
// Memory-mapped input port: debounced levels, sticky W1C edge flags,
// rising-edge counters for pins 0/1 and a registered interrupt.
module input_port_ctrl
    import input_port_pkg::*;
#(
    parameter int         NUM_INPUTS      = 2,
    parameter int         BUS_SIZE        = 32,
    parameter logic [7:0] BASE_ADDR       = 8'hF0,
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         CNT_WIDTH       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_INPUTS-1:0] inputPorts,
    input_port_ctrl_if.slave      bus,
    output logic                  irq
);

    logic [NUM_INPUTS-1:0] level_s, rise_pulse_s, fall_pulse_s;
    logic [NUM_INPUTS-1:0] rise_q, rise_d, fall_q, fall_d, bypass_q, bypass_d;
    logic [IRQMASK_W-1:0]  irq_mask_q, irq_mask_d;
    logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic                  irq_q, irq_d;
    logic                  hit_s, wr_s, rise0_s, rise1_s;
    logic [2:0]            offset_s;
    logic [BUS_SIZE-1:0]   rd_s;
    logic                  unused_wdata_s;

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_pin
        input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk        (clk),
            .rst        (rst),
            .pin        (inputPorts[i]),
            .bypass     (bypass_q[i]),
            .level      (level_s[i]),
            .rise_pulse (rise_pulse_s[i]),
            .fall_pulse (fall_pulse_s[i])
        );
    end

    assign rise0_s = rise_pulse_s[0];
    if (NUM_INPUTS >= 2) begin : g_cnt1_src
        assign rise1_s = rise_pulse_s[1];
    end else begin : g_no_cnt1_src
        assign rise1_s = 1'b0;
    end

    assign hit_s          = (bus.dirSelect[7:3] == BASE_ADDR[7:3]);
    assign offset_s       = bus.dirSelect[2:0];
    assign wr_s           = bus.wrEn & hit_s;
    assign unused_wdata_s = ^bus.writeData;

    // Register-file next state; a new edge beats a same-cycle W1C, a write beats a count
    always_comb begin
        rise_d     = rise_q;
        fall_d     = fall_q;
        bypass_d   = bypass_q;
        irq_mask_d = irq_mask_q;
        cnt0_d     = cnt0_q;
        cnt1_d     = cnt1_q;
        irq_d      = |((rise_q | fall_q) & irq_mask_q[NUM_INPUTS-1:0]);

        if (wr_s && (offset_s == OFF_RISE)) rise_d = rise_q & ~bus.writeData[NUM_INPUTS-1:0];
        else                                rise_d = rise_q;
        rise_d = rise_d | rise_pulse_s;

        if (wr_s && (offset_s == OFF_FALL)) fall_d = fall_q & ~bus.writeData[NUM_INPUTS-1:0];
        else                                fall_d = fall_q;
        fall_d = fall_d | fall_pulse_s;

        if (wr_s && (offset_s == OFF_CTRL)) begin
            bypass_d   = bus.writeData[BYPASS_LSB +: NUM_INPUTS];
            irq_mask_d = bus.writeData[IRQMASK_LSB +: IRQMASK_W];
        end else begin
            bypass_d   = bypass_q;
            irq_mask_d = irq_mask_q;
        end

        if (wr_s && (offset_s == OFF_CNT0)) cnt0_d = {CNT_WIDTH{1'b0}};
        else if (rise0_s)                   cnt0_d = cnt0_q + CNT_WIDTH'(1);
        else                                cnt0_d = cnt0_q;

        if (wr_s && (offset_s == OFF_CNT1)) cnt1_d = {CNT_WIDTH{1'b0}};
        else if (rise1_s)                   cnt1_d = cnt1_q + CNT_WIDTH'(1);
        else                                cnt1_d = cnt1_q;
    end

    // Register file flops with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q     <= {NUM_INPUTS{1'b0}};
            fall_q     <= {NUM_INPUTS{1'b0}};
            bypass_q   <= {NUM_INPUTS{1'b0}};
            irq_mask_q <= {IRQMASK_W{1'b0}};
            cnt0_q     <= {CNT_WIDTH{1'b0}};
            cnt1_q     <= {CNT_WIDTH{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            bypass_q   <= bypass_d;
            irq_mask_q <= irq_mask_d;
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            irq_q      <= irq_d;
        end
    end

    // Combinational read mux for the single-cycle load path
    always_comb begin
        rd_s = {BUS_SIZE{1'b0}};
        case (offset_s)
            OFF_LEVEL: rd_s[NUM_INPUTS-1:0] = level_s;
            OFF_RISE:  rd_s[NUM_INPUTS-1:0] = rise_q;
            OFF_FALL:  rd_s[NUM_INPUTS-1:0] = fall_q;
            OFF_CTRL: begin
                rd_s[BYPASS_LSB +: NUM_INPUTS] = bypass_q;
                rd_s[IRQMASK_LSB +: IRQMASK_W] = irq_mask_q;
            end
            OFF_CNT0:  rd_s[CNT_WIDTH-1:0] = cnt0_q;
            OFF_CNT1:  rd_s[CNT_WIDTH-1:0] = cnt1_q;
            default:   rd_s = {BUS_SIZE{1'b0}};
        endcase
    end

    assign bus.hit      = hit_s;
    assign bus.readData = hit_s ? rd_s : {BUS_SIZE{1'b0}};
    assign irq          = irq_q;

endmodule

// File: tb/tb_input_port_ctrl.sv
// Bench for input_port_ctrl: register table, directed timing/corner sequences,
// then randomized traffic against a behavioural model of the register map.
module tb_input_port_ctrl;

    localparam int         NI   = 2;
    localparam int         BS   = 32;
    localparam int         D    = 16;
    localparam int         CW   = 8;
    localparam logic [7:0] BASE = 8'hF0;

    logic          clk = 1'b0;
    logic          rst;
    logic [NI-1:0] pins;
    logic          irq;

    input_port_ctrl_if #(.BUS_SIZE(BS)) bus_if ();

    input_port_ctrl #(
        .NUM_INPUTS(NI), .BUS_SIZE(BS), .BASE_ADDR(BASE),
        .DEBOUNCE_CYCLES(D), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .inputPorts(pins), .bus(bus_if), .irq(irq)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int ecnt  = 0;

    // Behavioural model state
    logic [NI-1:0] m_level, m_rise, m_fall, m_bypass;
    logic [7:0]    m_mask;
    logic [CW-1:0] m_cnt0, m_cnt1;
    logic          m_irq;
    int            m_run [NI];
    logic [NI-1:0] m_hist [$];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t tbl [15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        logic [31:0] r;
        r = 32'h0;
        if (a[7:3] == BASE[7:3]) begin
            case (a[2:0])
                3'd0:    r = 32'(m_level);
                3'd1:    r = 32'(m_rise);
                3'd2:    r = 32'(m_fall);
                3'd3:    r = 32'(m_bypass) | (32'(m_mask) << 8);
                3'd4:    r = 32'(m_cnt0);
                3'd5:    r = 32'(m_cnt1);
                default: r = 32'h0;
            endcase
        end
        return r;
    endfunction

    // A pin value is seen by the debouncer two edges after it is sampled; a new
    // level is accepted after D consecutive differing observations (1 with bypass).
    task automatic model_step(input logic r, input logic [NI-1:0] p, input logic w,
                              input logic [7:0] a, input logic [31:0] wd);
        logic [NI-1:0] seen, ev_r, ev_f;
        logic          we, nirq;
        if (r) begin
            m_level = '0; m_rise = '0; m_fall = '0; m_bypass = '0; m_mask = '0;
            m_cnt0 = '0; m_cnt1 = '0; m_irq = 1'b0;
            for (int i = 0; i < NI; i++) m_run[i] = 0;
            m_hist = {};
            m_hist.push_back('0);
            m_hist.push_back('0);
        end else begin
            seen = m_hist[0];
            void'(m_hist.pop_front());
            m_hist.push_back(p);
            nirq = |((m_rise | m_fall) & m_mask[NI-1:0]);
            ev_r = '0;
            ev_f = '0;
            for (int i = 0; i < NI; i++) begin
                if (seen[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= D || m_bypass[i]) begin
                        m_level[i] = seen[i];
                        m_run[i]   = 0;
                        if (seen[i]) ev_r[i] = 1'b1;
                        else         ev_f[i] = 1'b1;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            we = w && (a[7:3] == BASE[7:3]);
            if (we && a[2:0] == 3'd1) m_rise = m_rise & ~wd[NI-1:0];
            if (we && a[2:0] == 3'd2) m_fall = m_fall & ~wd[NI-1:0];
            m_rise = m_rise | ev_r;
            m_fall = m_fall | ev_f;
            if (we && a[2:0] == 3'd3) begin
                m_bypass = wd[NI-1:0];
                m_mask   = wd[15:8];
            end
            if (we && a[2:0] == 3'd4) m_cnt0 = '0;
            else if (ev_r[0])         m_cnt0 = m_cnt0 + 1'b1;
            if (we && a[2:0] == 3'd5) m_cnt1 = '0;
            else if (ev_r[1])         m_cnt1 = m_cnt1 + 1'b1;
            m_irq = nirq;
        end
    endtask

    task automatic tick();
        model_step(rst, pins, bus_if.wrEn, bus_if.dirSelect, bus_if.writeData);
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus_if.dirSelect = a;
        bus_if.writeData = d;
        bus_if.wrEn      = 1'b1;
        tick();
        bus_if.wrEn      = 1'b0;
        bus_if.writeData = 32'h0;
    endtask

    task automatic chk_rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
        bus_if.dirSelect = a;
        #1;
        check(nm, bus_if.readData, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        ecnt = 0;
    endtask

    initial begin
        rst = 1'b0;
        pins = '0;
        bus_if.dirSelect = 8'h00;
        bus_if.wrEn      = 1'b0;
        bus_if.writeData = 32'h0;
        do_reset();

        // Address window, reset values and CTRL read-back
        tbl[0]  = '{1'b0, 8'hF0, 32'h0, 1'b1, 32'h0};
        tbl[1]  = '{1'b0, 8'hF1, 32'h0, 1'b1, 32'h0};
        tbl[2]  = '{1'b0, 8'hF2, 32'h0, 1'b1, 32'h0};
        tbl[3]  = '{1'b0, 8'hF3, 32'h0, 1'b1, 32'h0};
        tbl[4]  = '{1'b0, 8'hF4, 32'h0, 1'b1, 32'h0};
        tbl[5]  = '{1'b0, 8'hF5, 32'h0, 1'b1, 32'h0};
        tbl[6]  = '{1'b0, 8'hF6, 32'h0, 1'b1, 32'h0};
        tbl[7]  = '{1'b0, 8'hF7, 32'h0, 1'b1, 32'h0};
        tbl[8]  = '{1'b0, 8'hEF, 32'h0, 1'b0, 32'h0};
        tbl[9]  = '{1'b0, 8'hF8, 32'h0, 1'b0, 32'h0};
        tbl[10] = '{1'b1, 8'hF3, 32'h0000_FF03, 1'b1, 32'h0000_FF03};
        tbl[11] = '{1'b1, 8'hF3, 32'hFFFF_FFFF, 1'b1, 32'h0000_FF03};
        tbl[12] = '{1'b1, 8'hE3, 32'h0000_0000, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 8'hF6, 32'hFFFF_FFFF, 1'b1, 32'h0};
        tbl[14] = '{1'b0, 8'hF3, 32'h0, 1'b1, 32'h0000_FF03};
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].wr) wr(tbl[i].addr, tbl[i].wdata);
            chk_rd($sformatf("tbl%0d_rd", i), tbl[i].addr, tbl[i].exp_rd);
            check($sformatf("tbl%0d_hit", i), 32'(bus_if.hit), 32'(tbl[i].exp_hit));
            tick();
        end

        // Pin 0 rises after edge 10: LEVEL/RISE/CNT0 at edge 28, irq at edge 29
        do_reset();
        wr(8'hF3, 32'h0000_0100);
        while (ecnt < 10) tick();
        pins[0] = 1'b1;
        while (ecnt < 27) tick();
        chk_rd("lat_level_e27", 8'hF0, 32'h0);
        check("lat_irq_e27", 32'(irq), 32'h0);
        tick();
        chk_rd("lat_level_e28", 8'hF0, 32'h1);
        chk_rd("lat_rise_e28", 8'hF1, 32'h1);
        chk_rd("lat_cnt0_e28", 8'hF4, 32'h1);
        chk_rd("lat_fall_e28", 8'hF2, 32'h0);
        check("lat_irq_e28", 32'(irq), 32'h0);
        tick();
        check("lat_irq_e29", 32'(irq), 32'h1);

        // Glitch on pin 1 is filtered, a long pulse is accepted
        pins[1] = 1'b1; ticks(5); pins[1] = 1'b0; ticks(25);
        chk_rd("glitch_level", 8'hF0, 32'h1);
        chk_rd("glitch_rise", 8'hF1, 32'h1);
        chk_rd("glitch_fall", 8'hF2, 32'h0);
        chk_rd("glitch_cnt1", 8'hF5, 32'h0);
        pins[1] = 1'b1; ticks(20);
        chk_rd("hold_level", 8'hF0, 32'h3);
        chk_rd("hold_rise", 8'hF1, 32'h3);
        pins[1] = 1'b0; ticks(20);
        chk_rd("rel_level", 8'hF0, 32'h1);
        chk_rd("rel_fall", 8'hF2, 32'h2);
        chk_rd("rel_cnt1", 8'hF5, 32'h1);

        // W1C coincident with a new rising edge: set wins
        wr(8'hF3, 32'h0000_0101);
        wr(8'hF1, 32'h3);
        wr(8'hF2, 32'h3);
        pins[0] = 1'b0; ticks(5);
        chk_rd("w1c_fall_set", 8'hF2, 32'h1);
        wr(8'hF2, 32'h1);
        chk_rd("w1c_fall_clr", 8'hF2, 32'h0);
        pins[0] = 1'b1; ticks(2);
        wr(8'hF1, 32'h1);
        chk_rd("w1c_set_wins", 8'hF1, 32'h1);
        wr(8'hF1, 32'h1);
        chk_rd("w1c_clear", 8'hF1, 32'h0);

        // Counter wrap and write-beats-increment
        pins[0] = 1'b0; ticks(4);
        wr(8'hF4, 32'h0);
        chk_rd("cnt_clr", 8'hF4, 32'h0);
        for (int k = 0; k < 255; k++) begin
            pins[0] = 1'b1; ticks(2);
            pins[0] = 1'b0; ticks(2);
        end
        chk_rd("cnt_full", 8'hF4, 32'hFF);
        pins[0] = 1'b1; ticks(4);
        chk_rd("cnt_wrap", 8'hF4, 32'h0);
        pins[0] = 1'b0; ticks(4);
        pins[0] = 1'b1; ticks(2);
        wr(8'hF4, 32'hDEAD);
        chk_rd("cnt_wr_wins", 8'hF4, 32'h0);
        ticks(3);
        chk_rd("cnt_wr_hold", 8'hF4, 32'h0);

        // Reset mid-debounce aborts the change; pin held high re-qualifies from scratch
        pins = '0;
        do_reset();
        pins = 2'b01;
        ticks(10);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_rd("rst_level", 8'hF0, 32'h0);
        chk_rd("rst_rise", 8'hF1, 32'h0);
        chk_rd("rst_ctrl", 8'hF3, 32'h0);
        chk_rd("rst_cnt0", 8'hF4, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        ticks(17);
        chk_rd("rst_rise_e17", 8'hF1, 32'h0);
        tick();
        chk_rd("rst_rise_e18", 8'hF1, 32'h1);
        chk_rd("rst_level_e18", 8'hF0, 32'h1);

        // Randomized traffic against the model
        pins = '0;
        do_reset();
        for (int it = 0; it < 4000; it++) begin
            for (int i = 0; i < NI; i++)
                if ($urandom_range(0, 11) == 0) pins[i] = ~pins[i];
            rst = ($urandom_range(0, 599) == 0);
            bus_if.wrEn = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 9) == 0) bus_if.dirSelect = 8'($urandom);
            else bus_if.dirSelect = {BASE[7:3], 3'($urandom_range(0, 7))};
            bus_if.writeData = $urandom;
            #1;
            check("rnd_rd", bus_if.readData, model_read(bus_if.dirSelect));
            check("rnd_hit", 32'(bus_if.hit), 32'(bus_if.dirSelect[7:3] == BASE[7:3]));
            tick();
            check("rnd_irq", 32'(irq), 32'(m_irq));
        end
        rst = 1'b0;
        bus_if.wrEn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
